// File: rtl/mult_div_if.sv
// Request/result bundle between the multicycle control unit and mult_div_unit.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  // Handshake: the master holds start high for one clock with op/a/b valid;
  // the request is taken on that rising edge only when the unit is idle or
  // in its done cycle (busy low). Results in hi/lo, together with div_zero,
  // are valid from the cycle where done pulses and hold until the next
  // completion. done is a single-cycle pulse and needs no acknowledge.
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) unit.
// Results land atomically in hi/lo: product high/low for mult,
// remainder/quotient for div.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  md,
  output logic [2:0] o_dbg_state
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_accept;

  // Shared work register: {acc, q, q-1}. For div, acc is the partial
  // remainder and q shifts the dividend out while the quotient shifts in.
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_qm1;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_cnt;
  logic             r_a_neg;
  logic             r_b_neg;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_div_zero;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_acc_ext;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_fits;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;
  logic [WIDTH-1:0] w_quo_signed;
  logic [WIDTH-1:0] w_rem_signed;

  // Magnitudes: -2^(W-1) maps to 2^(W-1), which still fits unsigned.
  assign w_abs_a = md.a[WIDTH-1] ? -md.a : md.a;
  assign w_abs_b = md.b[WIDTH-1] ? -md.b : md.b;

  // Booth step: the sum is one bit wider than acc so that subtracting the
  // most negative multiplicand cannot overflow before the arithmetic shift.
  always_comb begin
    w_acc_ext   = {r_acc[WIDTH-1], r_acc};
    w_m_ext     = {r_m[WIDTH-1], r_m};
    w_booth_sum = w_acc_ext;
    case ({r_q[0], r_qm1})
      2'b01:   w_booth_sum = w_acc_ext + w_m_ext;
      2'b10:   w_booth_sum = w_acc_ext - w_m_ext;
      default: w_booth_sum = w_acc_ext;
    endcase
  end

  // Restoring step: the remainder stays below |b| <= 2^(W-1), so the shifted
  // value fits in W bits and the top bit of the difference is the borrow.
  assign w_div_shift  = {r_acc, r_q[WIDTH-1]};
  assign w_div_diff   = w_div_shift - {1'b0, r_m};
  assign w_div_fits   = ~w_div_diff[WIDTH];
  assign w_div_rem    = w_div_fits ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
  assign w_div_quo    = {r_q[WIDTH-2:0], w_div_fits};

  // Sign fix-up: quotient truncates toward zero, remainder follows the dividend.
  assign w_quo_signed = (r_a_neg ^ r_b_neg) ? -r_q : r_q;
  assign w_rem_signed = r_a_neg ? -r_acc : r_acc;

  // Next-state logic; a new request is taken only in IDLE or DONE.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_next_state = S_IDLE;
        if (md.start) begin
          w_accept = 1'b1;
          if (!md.op)             w_next_state = S_MULT;
          else if (md.b == '0)    w_next_state = S_DONE;
          else                    w_next_state = S_DIV;
        end
      end
      S_MULT:  if (r_cnt == LAST) w_next_state = S_DONE;
      S_DIV:   if (r_cnt == LAST) w_next_state = S_FIX;
      S_FIX:   w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Registered busy/done decoded from the upcoming state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next_state == S_MULT) || (w_next_state == S_DIV) ||
                (w_next_state == S_FIX);
      r_done <= (w_next_state == S_DONE);
    end
  end

  // Datapath: operand capture, per-cycle iteration and result write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_q        <= '0;
      r_qm1      <= 1'b0;
      r_m        <= '0;
      r_cnt      <= '0;
      r_a_neg    <= 1'b0;
      r_b_neg    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_qm1      <= 1'b0;
            r_a_neg    <= md.a[WIDTH-1];
            r_b_neg    <= md.b[WIDTH-1];
            r_div_zero <= md.op && (md.b == '0);
            if (!md.op) begin
              r_m <= md.a;
              r_q <= md.b;
            end else begin
              r_m <= w_abs_b;
              r_q <= w_abs_a;
            end
          end
        end
        S_MULT: begin
          r_acc <= w_booth_sum[WIDTH:1];
          r_q   <= {w_booth_sum[0], r_q[WIDTH-1:1]};
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_hi <= w_booth_sum[WIDTH:1];
            r_lo <= {w_booth_sum[0], r_q[WIDTH-1:1]};
          end
        end
        S_DIV: begin
          r_acc <= w_div_rem;
          r_q   <= w_div_quo;
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_hi <= w_rem_signed;
          r_lo <= w_quo_signed;
        end
        default: ;
      endcase
    end
  end

  assign md.busy     = r_busy;
  assign md.done     = r_done;
  assign md.div_zero = r_div_zero;
  assign md.hi       = r_hi;
  assign md.lo       = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: products, signed division, divide by
// zero, ignored restarts, back-to-back issue and asynchronous reset abort.
module tb_mult_div_unit;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;
  int         checks;
  int         errors;
  int         edge_idx;
  int         busy_cnt;
  int         done_cnt;

  mult_div_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .md          (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Driver: caller sits 1 time unit after a rising edge. Presents a request
  // for one edge, then scrambles the operands to show they were captured.
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 1'($urandom_range(0, 1));
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Waits for done; edge index 0 is the sample right after the accepting edge.
  task automatic wait_done(output int idx, output int nbusy);
    idx   = -1;
    nbusy = 0;
    for (int k = 0; k <= 100; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (bus.busy) nbusy++;
      if (bus.done) begin idx = k; break; end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset done got %b exp 0", bus.done); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset div_zero got %b exp 0", bus.div_zero); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset hi got %h exp 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset lo got %h exp 00000000", bus.lo); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset state got %0d exp 0", dbg_state); end
    reset = 1'b0;
    idle_cycle();
  endtask

  task automatic test_mult_basic();
    issue(1'b0, 32'd7, 32'hFFFFFFFD);
    wait_done(edge_idx, busy_cnt);
    checks++; if (edge_idx !== 32) begin errors++; $display("FAIL mult_7x-3 done_edge got %0d exp 32", edge_idx); end
    checks++; if (busy_cnt !== 32) begin errors++; $display("FAIL mult_7x-3 busy_cycles got %0d exp 32", busy_cnt); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_7x-3 hi got %h exp ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_7x-3 lo got %h exp ffffffeb", bus.lo); end
    idle_cycle();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_7x-3 done_width got %b exp 0", bus.done); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_7x-3 hi_hold got %h exp ffffffff", bus.hi); end
  endtask

  task automatic test_mult_corners();
    issue(1'b0, 32'h80000000, 32'h80000000);
    wait_done(edge_idx, busy_cnt);
    checks++; if (edge_idx !== 32) begin errors++; $display("FAIL mult_min2 done_edge got %0d exp 32", edge_idx); end
    checks++; if (bus.hi !== 32'h40000000) begin errors++; $display("FAIL mult_min2 hi got %h exp 40000000", bus.hi); end
    checks++; if (bus.lo !== 32'h00000000) begin errors++; $display("FAIL mult_min2 lo got %h exp 00000000", bus.lo); end
    idle_cycle();
    issue(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF);
    wait_done(edge_idx, busy_cnt);
    checks++; if (bus.hi !== 32'h3FFFFFFF) begin errors++; $display("FAIL mult_max2 hi got %h exp 3fffffff", bus.hi); end
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("FAIL mult_max2 lo got %h exp 00000001", bus.lo); end
    idle_cycle();
  endtask

  task automatic test_div();
    // -7 / 2 -> q=-3, r=-1
    issue(1'b1, 32'hFFFFFFF9, 32'd2);
    wait_done(edge_idx, busy_cnt);
    checks++; if (edge_idx !== 33) begin errors++; $display("FAIL div_-7/2 done_edge got %0d exp 33", edge_idx); end
    checks++; if (busy_cnt !== 33) begin errors++; $display("FAIL div_-7/2 busy_cycles got %0d exp 33", busy_cnt); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_-7/2 lo got %h exp fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_-7/2 hi got %h exp ffffffff", bus.hi); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL div_-7/2 div_zero got %b exp 0", bus.div_zero); end
    idle_cycle();
    // 7 / -2 -> q=-3, r=1
    issue(1'b1, 32'd7, 32'hFFFFFFFE);
    wait_done(edge_idx, busy_cnt);
    checks++; if (edge_idx !== 33) begin errors++; $display("FAIL div_7/-2 done_edge got %0d exp 33", edge_idx); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_7/-2 lo got %h exp fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'h00000001) begin errors++; $display("FAIL div_7/-2 hi got %h exp 00000001", bus.hi); end
    idle_cycle();
    // -2^31 / -1 wraps to -2^31 with zero remainder
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done(edge_idx, busy_cnt);
    checks++; if (edge_idx !== 33) begin errors++; $display("FAIL div_min/-1 done_edge got %0d exp 33", edge_idx); end
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL div_min/-1 lo got %h exp 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h00000000) begin errors++; $display("FAIL div_min/-1 hi got %h exp 00000000", bus.hi); end
    idle_cycle();
    // -100 / -7 -> q=14, r=-2
    issue(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9);
    wait_done(edge_idx, busy_cnt);
    checks++; if (bus.lo !== 32'h0000000E) begin errors++; $display("FAIL div_-100/-7 lo got %h exp 0000000e", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL div_-100/-7 hi got %h exp fffffffe", bus.hi); end
    idle_cycle();
  endtask

  task automatic test_div_zero();
    // 0x12345679 * 0x7FFFFFFF = 0x091A2B3C_6DCBA987
    issue(1'b0, 32'h12345679, 32'h7FFFFFFF);
    wait_done(edge_idx, busy_cnt);
    checks++; if (bus.hi !== 32'h091A2B3C) begin errors++; $display("FAIL preload hi got %h exp 091a2b3c", bus.hi); end
    checks++; if (bus.lo !== 32'h6DCBA987) begin errors++; $display("FAIL preload lo got %h exp 6dcba987", bus.lo); end
    idle_cycle();
    issue(1'b1, 32'd5, 32'd0);
    wait_done(edge_idx, busy_cnt);
    checks++; if (edge_idx !== 0) begin errors++; $display("FAIL divzero done_edge got %0d exp 0", edge_idx); end
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL divzero busy_cycles got %0d exp 0", busy_cnt); end
    checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL divzero flag got %b exp 1", bus.div_zero); end
    checks++; if (bus.hi !== 32'h091A2B3C) begin errors++; $display("FAIL divzero hi_kept got %h exp 091a2b3c", bus.hi); end
    checks++; if (bus.lo !== 32'h6DCBA987) begin errors++; $display("FAIL divzero lo_kept got %h exp 6dcba987", bus.lo); end
    idle_cycle();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL divzero done_width got %b exp 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL divzero busy_after got %b exp 0", bus.busy); end
    checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL divzero flag_held got %b exp 1", bus.div_zero); end
    issue(1'b0, 32'd3, 32'd5);
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL divzero flag_clear got %b exp 0", bus.div_zero); end
    wait_done(edge_idx, busy_cnt);
    checks++; if (bus.lo !== 32'd15) begin errors++; $display("FAIL mult_3x5 lo got %h exp 0000000f", bus.lo); end
    idle_cycle();
  endtask

  task automatic test_restart_ignored();
    // 0x123 * 0x456 = 0x4EDC2; restarts at edges 5 and 20 must be ignored.
    issue(1'b0, 32'h00000123, 32'h00000456);
    edge_idx = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 4 || k == 19) begin
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'd5; bus.b = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin edge_idx = k; break; end
    end
    bus.start = 1'b0;
    checks++; if (edge_idx !== 32) begin errors++; $display("FAIL restart done_edge got %0d exp 32", edge_idx); end
    checks++; if (bus.lo !== 32'h0004EDC2) begin errors++; $display("FAIL restart lo got %h exp 0004edc2", bus.lo); end
    checks++; if (bus.hi !== 32'h00000000) begin errors++; $display("FAIL restart hi got %h exp 00000000", bus.hi); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL restart div_zero got %b exp 0", bus.div_zero); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 32'hFFFFFFFB, 32'd6);
    wait_done(edge_idx, busy_cnt);
    checks++; if (edge_idx !== 32) begin errors++; $display("FAIL b2b_first done_edge got %0d exp 32", edge_idx); end
    checks++; if (bus.lo !== 32'hFFFFFFE2) begin errors++; $display("FAIL b2b_first lo got %h exp ffffffe2", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_first hi got %h exp ffffffff", bus.hi); end
    // Issue during the done cycle: 100 / 7 -> q=14, r=2
    issue(1'b1, 32'd100, 32'd7);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_second busy got %b exp 1", bus.busy); end
    wait_done(edge_idx, busy_cnt);
    checks++; if (edge_idx !== 33) begin errors++; $display("FAIL b2b_second done_edge got %0d exp 33", edge_idx); end
    checks++; if (bus.lo !== 32'h0000000E) begin errors++; $display("FAIL b2b_second lo got %h exp 0000000e", bus.lo); end
    checks++; if (bus.hi !== 32'h00000002) begin errors++; $display("FAIL b2b_second hi got %h exp 00000002", bus.hi); end
    idle_cycle();
  endtask

  task automatic test_reset_abort();
    issue(1'b1, 32'd1000, 32'd3);
    done_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort done got %b exp 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL abort hi got %h exp 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL abort lo got %h exp 00000000", bus.lo); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL abort state got %0d exp 0", dbg_state); end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort done_pulses got %0d exp 0", done_cnt); end
    issue(1'b0, 32'd3, 32'd4);
    wait_done(edge_idx, busy_cnt);
    checks++; if (edge_idx !== 32) begin errors++; $display("FAIL post_reset done_edge got %0d exp 32", edge_idx); end
    checks++; if (bus.lo !== 32'd12) begin errors++; $display("FAIL post_reset lo got %h exp 0000000c", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL post_reset hi got %h exp 00000000", bus.hi); end
    idle_cycle();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_mult_basic();
    test_mult_corners();
    test_div();
    test_div_zero();
    test_restart_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
